// File: rtl/clock_set_controller_pkg.sv
// ----------------------------------------------------------------------------
// clock_set_controller_pkg
//
// Shared definitions for the digital clock time-setting path: the mode
// encoding seen on o_Mode, the digit positions of the four-digit display,
// and small helpers used by the mode sequencer.
//
// Digit order (bit index of the blank mask):
//   3 = hour tens, 2 = hour units, 1 = minute tens, 0 = minute units
// ----------------------------------------------------------------------------
package clock_set_controller_pkg;

   // Mode encoding, shared with the display mux and the timekeeper.
   typedef enum logic [1:0] {
      MODE_NORMAL   = 2'b00,
      MODE_ARMED    = 2'b01,
      MODE_SET_MIN  = 2'b10,
      MODE_SET_HOUR = 2'b11
   } mode_e;

   // Digit positions on the display.
   localparam int NUM_DIGITS       = 4;
   localparam int DIGIT_MIN_UNITS  = 0;
   localparam int DIGIT_MIN_TENS   = 1;
   localparam int DIGIT_HOUR_UNITS = 2;
   localparam int DIGIT_HOUR_TENS  = 3;

   // Successor of a mode in the Set-button cycle
   // NORMAL -> ARMED -> SET_MIN -> SET_HOUR -> NORMAL.
   function automatic mode_e nextMode(input mode_e mode);
      mode_e result;
      case (mode)
         MODE_NORMAL:   result = MODE_ARMED;
         MODE_ARMED:    result = MODE_SET_MIN;
         MODE_SET_MIN:  result = MODE_SET_HOUR;
         default:       result = MODE_NORMAL;
      endcase
      return result;
   endfunction

   // Blank mask for a mode during the OFF half of the blink period.
   // ARMED blanks everything so the user sees that Set was registered;
   // the edit modes blank only the field being edited.  Outside the OFF
   // phase, and always in NORMAL, nothing is blanked.
   function automatic logic [NUM_DIGITS-1:0] blankMask(input mode_e mode,
                                                       input logic  offPhase);
      logic [NUM_DIGITS-1:0] mask;
      mask = '0;
      if (offPhase) begin
         case (mode)
            MODE_ARMED: begin
               mask = '1;
            end
            MODE_SET_MIN: begin
               mask[DIGIT_MIN_UNITS] = 1'b1;
               mask[DIGIT_MIN_TENS]  = 1'b1;
            end
            MODE_SET_HOUR: begin
               mask[DIGIT_HOUR_UNITS] = 1'b1;
               mask[DIGIT_HOUR_TENS]  = 1'b1;
            end
            default: begin
               mask = '0;
            end
         endcase
      end
      return mask;
   endfunction

endpackage

// File: rtl/clock_up_repeater.sv
// ----------------------------------------------------------------------------
// clock_up_repeater
//
// Auto-repeat generator for the Up button.  A press pulse arms the
// repeater; while the Up level stays high the first repeat request comes
// REPEAT_DELAY cycles after the press, then one every REPEAT_RATE cycles.
// Releasing the button or asserting i_Clear disarms it.  A held level that
// was never preceded by a press pulse never produces a repeat.
//
// Ports:
//   i_Clock    system clock
//   i_Reset_n  asynchronous active-low reset
//   i_Clear    disarm and zero the counter (mode change / not editing)
//   i_Start    press pulse: arm and restart the delay count
//   i_Level    debounced Up level, 1 = held
//   o_Repeat   combinational repeat request, valid in the cycle it is high
// ----------------------------------------------------------------------------
module clock_up_repeater #(
   parameter int REPEAT_DELAY = 16384,
   parameter int REPEAT_RATE  = 4096
) (
   input  logic i_Clock,
   input  logic i_Reset_n,
   input  logic i_Clear,
   input  logic i_Start,
   input  logic i_Level,
   output logic o_Repeat
);

   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] DELAY_C = CW'(REPEAT_DELAY);
   localparam logic [CW-1:0] RATE_C  = CW'(REPEAT_RATE);
   localparam logic [CW-1:0] MAX_C   = CW'(CNT_MAX);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   logic          active_q, active_d;
   logic          repeating_q, repeating_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // The counter holds the number of cycles since the press (or since the
   // last repeat), so a request is raised once it reaches the threshold of
   // the current phase: the long initial delay, then the shorter rate.
   assign o_Repeat = active_q && i_Level &&
                     (repeating_q ? (cnt_q >= RATE_C) : (cnt_q >= DELAY_C));

   // Next-state logic.  Clear beats a new press, a new press restarts the
   // delay phase, and a release drops everything back to idle.
   always_comb begin
      active_d    = active_q;
      repeating_d = repeating_q;
      cnt_d       = cnt_q;
      if (i_Clear) begin
         active_d    = 1'b0;
         repeating_d = 1'b0;
         cnt_d       = '0;
      end else if (i_Start) begin
         active_d    = 1'b1;
         repeating_d = 1'b0;
         cnt_d       = ONE_C;
      end else if (!active_q || !i_Level) begin
         active_d    = 1'b0;
         repeating_d = 1'b0;
         cnt_d       = '0;
      end else if (o_Repeat) begin
         repeating_d = 1'b1;
         cnt_d       = ONE_C;
      end else if (cnt_q < MAX_C) begin
         cnt_d = cnt_q + ONE_C;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         active_q    <= 1'b0;
         repeating_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         active_q    <= active_d;
         repeating_q <= repeating_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule

// File: rtl/clock_set_controller.sv
// ----------------------------------------------------------------------------
// clock_set_controller
//
// Mode sequencer for the digital clock.  Takes debounced Set/Up events and
// walks the time-setting flow NORMAL -> ARMED -> SET_MIN -> SET_HOUR ->
// NORMAL, emitting increment strobes to the timekeeper, a run enable, and a
// blink mask for the display mux.  An idle timeout returns to NORMAL.
//
// Ports:
//   i_Clock         system clock
//   i_Reset_n       asynchronous active-low reset
//   i_Set_Pulse     debounced Set press, single-cycle
//   i_Up_Pulse      debounced Up press, single-cycle
//   i_Up_Level      debounced Up level, 1 = held
//   o_Mode          current mode (see mode_e)
//   o_Run_En        1 = timekeeper counts seconds (NORMAL only)
//   o_Inc_Min       single-cycle minute increment strobe
//   o_Inc_Hour      single-cycle hour increment strobe
//   o_Clear_Sec     single-cycle strobe to zero seconds on leaving SET_HOUR
//   o_Blank_Digits  per-digit blank mask, [3] hour tens .. [0] minute units
//
// All outputs are registered: each is computed from the next state, so a
// pulse sampled on one edge shows up on the outputs right after that edge.
// ----------------------------------------------------------------------------
module clock_set_controller
   import clock_set_controller_pkg::*;
#(
   parameter int TICKS_PER_SEC = 32768,
   parameter int BLINK_HALF    = 16384,
   parameter int REPEAT_DELAY  = 16384,
   parameter int REPEAT_RATE   = 4096,
   parameter int TIMEOUT_SEC   = 30
) (
   input  logic                  i_Clock,
   input  logic                  i_Reset_n,
   input  logic                  i_Set_Pulse,
   input  logic                  i_Up_Pulse,
   input  logic                  i_Up_Level,
   output logic [1:0]            o_Mode,
   output logic                  o_Run_En,
   output logic                  o_Inc_Min,
   output logic                  o_Inc_Hour,
   output logic                  o_Clear_Sec,
   output logic [NUM_DIGITS-1:0] o_Blank_Digits
);

   localparam int TICK_W  = $clog2(TICKS_PER_SEC + 1);
   localparam int SEC_W   = $clog2(TIMEOUT_SEC + 1);
   localparam int BLINK_W = $clog2(2 * BLINK_HALF + 1);

   localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICKS_PER_SEC - 1);
   localparam logic [TICK_W-1:0]  TICK_ONE   = TICK_W'(1);
   localparam logic [SEC_W-1:0]   SEC_LAST   = SEC_W'(TIMEOUT_SEC - 1);
   localparam logic [SEC_W-1:0]   SEC_MAX    = SEC_W'(TIMEOUT_SEC);
   localparam logic [SEC_W-1:0]   SEC_ONE    = SEC_W'(1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(2 * BLINK_HALF - 1);
   localparam logic [BLINK_W-1:0] BLINK_OFF  = BLINK_W'(BLINK_HALF);
   localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);

   mode_e                 mode_q, mode_d;
   logic                  runEn_q, runEn_d;
   logic                  incMin_q, incMin_d;
   logic                  incHour_q, incHour_d;
   logic                  clearSec_q, clearSec_d;
   logic [NUM_DIGITS-1:0] blank_q, blank_d;
   logic [TICK_W-1:0]     tick_q, tick_d;
   logic [SEC_W-1:0]      sec_q, sec_d;
   logic [BLINK_W-1:0]    blink_q, blink_d;

   logic editing;
   logic upEff;
   logic tickWrap;
   logic timeoutHit;
   logic modeChange;
   logic incReq;
   logic repStart;
   logic repClear;
   logic repeatFire;

   // Up only means something while a field is being edited, and a Set in
   // the same cycle swallows it.
   assign editing  = (mode_q == MODE_SET_MIN) || (mode_q == MODE_SET_HOUR);
   assign upEff    = i_Up_Pulse && !i_Set_Pulse;
   assign tickWrap = (tick_q >= TICK_LAST);

   // The timeout fires on the last cycle of the final idle second.  An Up
   // press in that cycle restarts the idle time instead, and a Set press is
   // handled ahead of the timeout by the mode logic below.
   assign timeoutHit = (mode_q != MODE_NORMAL) && !i_Up_Pulse &&
                       tickWrap && (sec_q >= SEC_LAST);

   // Mode next-state: Set advances the cycle and wins over a timeout.
   always_comb begin
      mode_d = mode_q;
      if (i_Set_Pulse) begin
         mode_d = nextMode(mode_q);
      end else if (timeoutHit) begin
         mode_d = MODE_NORMAL;
      end
   end

   assign modeChange = (mode_d != mode_q);
   assign repClear   = modeChange || !editing;
   assign repStart   = upEff && editing;

   // A press and a repeat request in the same cycle still make only one
   // strobe; anything that coincides with a mode change is dropped.
   assign incReq = editing && !modeChange && (upEff || repeatFire);

   clock_up_repeater #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
   ) u_upRepeater (
      .i_Clock   (i_Clock),
      .i_Reset_n (i_Reset_n),
      .i_Clear   (repClear),
      .i_Start   (repStart),
      .i_Level   (i_Up_Level),
      .o_Repeat  (repeatFire)
   );

   // Strobes and run enable.  Seconds are cleared only when the user
   // finishes the edit with Set, never when the timeout bails out.
   always_comb begin
      incMin_d   = incReq && (mode_q == MODE_SET_MIN);
      incHour_d  = incReq && (mode_q == MODE_SET_HOUR);
      clearSec_d = i_Set_Pulse && (mode_q == MODE_SET_HOUR);
      runEn_d    = (mode_d == MODE_NORMAL);
   end

   // Idle timer: a sub-second tick prescaler feeding a whole-second count.
   // It only runs while editing and restarts on any button press or mode
   // change.  The second count saturates so it can never wrap past the
   // timeout threshold.
   always_comb begin
      tick_d = tick_q;
      sec_d  = sec_q;
      if ((mode_d == MODE_NORMAL) || i_Set_Pulse || i_Up_Pulse || modeChange) begin
         tick_d = '0;
         sec_d  = '0;
      end else if (tickWrap) begin
         tick_d = '0;
         if (sec_q < SEC_MAX) begin
            sec_d = sec_q + SEC_ONE;
         end
      end else begin
         tick_d = tick_q + TICK_ONE;
      end
   end

   // Blink phase: first half of the period is ON, second half OFF.  It
   // restarts on every mode change and every increment so the edited field
   // is visible right after each edit.  It sits at zero in NORMAL.
   always_comb begin
      blink_d = blink_q;
      if ((mode_d == MODE_NORMAL) || modeChange || incMin_d || incHour_d) begin
         blink_d = '0;
      end else if (blink_q >= BLINK_LAST) begin
         blink_d = '0;
      end else begin
         blink_d = blink_q + BLINK_ONE;
      end
      blank_d = blankMask(mode_d, (blink_d >= BLINK_OFF));
   end

   // State and output registers with asynchronous reset.  Reset lands in
   // NORMAL with the timekeeper running and every strobe low.
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         mode_q     <= MODE_NORMAL;
         runEn_q    <= 1'b1;
         incMin_q   <= 1'b0;
         incHour_q  <= 1'b0;
         clearSec_q <= 1'b0;
         blank_q    <= '0;
         tick_q     <= '0;
         sec_q      <= '0;
         blink_q    <= '0;
      end else begin
         mode_q     <= mode_d;
         runEn_q    <= runEn_d;
         incMin_q   <= incMin_d;
         incHour_q  <= incHour_d;
         clearSec_q <= clearSec_d;
         blank_q    <= blank_d;
         tick_q     <= tick_d;
         sec_q      <= sec_d;
         blink_q    <= blink_d;
      end
   end

   assign o_Mode         = mode_q;
   assign o_Run_En       = runEn_q;
   assign o_Inc_Min      = incMin_q;
   assign o_Inc_Hour     = incHour_q;
   assign o_Clear_Sec    = clearSec_q;
   assign o_Blank_Digits = blank_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// ----------------------------------------------------------------------------
// tb_clock_set_controller
//
// Bench for the clock mode sequencer with shortened timing parameters.
// A behavioural model tracks mode, idle time, time since the last Up press
// and blink phase as plain integers and predicts every output each cycle.
// ----------------------------------------------------------------------------
module tb_clock_set_controller;

   localparam int TPS = 64;
   localparam int BH  = 8;
   localparam int RD  = 20;
   localparam int RR  = 5;
   localparam int TS  = 3;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       setPulse;
   logic       upPulse;
   logic       upLevel;
   logic [1:0] mode;
   logic       runEn;
   logic       incMin;
   logic       incHour;
   logic       clearSec;
   logic [3:0] blank;

   int errorCount = 0;
   int checkCount = 0;

   // Behavioural model state.
   int mMode;
   int mIdle;
   bit mHolding;
   int mAge;
   int mBlink;

   // Model predictions for the outputs after the current edge.
   int eMode;
   bit eRun;
   bit eMin;
   bit eHour;
   bit eClr;
   int eBlank;

   // Observed strobe totals, used by the directed scenarios.
   int obsMin  = 0;
   int obsHour = 0;
   int obsClr  = 0;

   clock_set_controller #(
      .TICKS_PER_SEC (TPS),
      .BLINK_HALF    (BH),
      .REPEAT_DELAY  (RD),
      .REPEAT_RATE   (RR),
      .TIMEOUT_SEC   (TS)
   ) dut (
      .i_Clock        (clock),
      .i_Reset_n      (reset_n),
      .i_Set_Pulse    (setPulse),
      .i_Up_Pulse     (upPulse),
      .i_Up_Level     (upLevel),
      .o_Mode         (mode),
      .o_Run_En       (runEn),
      .o_Inc_Min      (incMin),
      .o_Inc_Hour     (incHour),
      .o_Clear_Sec    (clearSec),
      .o_Blank_Digits (blank)
   );

   // Free-running 10 ns clock.
   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic int maskFor(input int m);
      case (m)
         1:       return 15;
         2:       return 3;
         3:       return 12;
         default: return 0;
      endcase
   endfunction

   task automatic modelReset();
      mMode    = 0;
      mIdle    = 0;
      mHolding = 0;
      mAge     = 0;
      mBlink   = 0;
      eMode    = 0;
      eRun     = 1;
      eMin     = 0;
      eHour    = 0;
      eClr     = 0;
      eBlank   = 0;
   endtask

   // One cycle of the reference: given this cycle's inputs, decide the
   // mode and strobes that appear after the edge.
   task automatic modelStep(input bit s, input bit u, input bit l);
      int  nm;
      int  idleNow;
      int  age;
      bit  changed;
      bit  fire;
      bit  press;
      bit  strobe;
      idleNow = mIdle + 1;
      if (s)
         nm = (mMode + 1) % 4;
      else if (mMode != 0 && !u && idleNow >= TS * TPS)
         nm = 0;
      else
         nm = mMode;
      changed = (nm != mMode);
      press   = u && !s;
      age     = mAge + 1;
      fire    = 0;
      if (mHolding && l)
         fire = (age == RD) || (age > RD && ((age - RD) % RR) == 0);
      strobe = (mMode >= 2) && !changed && (press || fire);

      if (changed || mMode < 2)
         mHolding = 0;
      else if (press) begin
         mHolding = 1;
         mAge     = 0;
      end else if (mHolding && !l)
         mHolding = 0;
      else if (mHolding)
         mAge = age;

      if (nm == 0 || changed || s || u)
         mIdle = 0;
      else
         mIdle = idleNow;

      if (nm == 0 || changed || strobe)
         mBlink = 0;
      else
         mBlink = (mBlink + 1) % (2 * BH);

      eMode  = nm;
      eRun   = (nm == 0);
      eMin   = strobe && (mMode == 2);
      eHour  = strobe && (mMode == 3);
      eClr   = s && (mMode == 3);
      eBlank = (mBlink >= BH) ? maskFor(nm) : 0;
      mMode  = nm;
   endtask

   task automatic checkAll(input string phase);
      checkOutput({phase, ":mode"},  32'(mode),     eMode);
      checkOutput({phase, ":run"},   32'(runEn),    32'(eRun));
      checkOutput({phase, ":min"},   32'(incMin),   32'(eMin));
      checkOutput({phase, ":hour"},  32'(incHour),  32'(eHour));
      checkOutput({phase, ":clr"},   32'(clearSec), 32'(eClr));
      checkOutput({phase, ":blank"}, 32'(blank),    eBlank);
   endtask

   // Drive one cycle of inputs, let the edge happen, then compare.
   task automatic applyStimulus(input string phase, input bit s, input bit u, input bit l);
      setPulse = s;
      upPulse  = u;
      upLevel  = l;
      @(posedge clock);
      modelStep(s, u, l);
      #1;
      checkAll(phase);
      obsMin  += int'(incMin);
      obsHour += int'(incHour);
      obsClr  += int'(clearSec);
   endtask

   task automatic idleCycles(input string phase, input int n);
      for (int i = 0; i < n; i++) applyStimulus(phase, 0, 0, 0);
   endtask

   task automatic checkResetValues(input string phase);
      checkOutput({phase, ":mode"},  32'(mode),     0);
      checkOutput({phase, ":run"},   32'(runEn),    1);
      checkOutput({phase, ":min"},   32'(incMin),   0);
      checkOutput({phase, ":hour"},  32'(incHour),  0);
      checkOutput({phase, ":clr"},   32'(clearSec), 0);
      checkOutput({phase, ":blank"}, 32'(blank),    0);
   endtask

   initial begin
      int setModes[4];
      int holdExp[6];
      int holdSeen[$];
      int base;
      int holdLeft;
      bit s, u, l;

      setModes = '{1, 2, 3, 0};
      holdExp  = '{1, 21, 26, 31, 36, 41};

      reset_n  = 1'b0;
      setPulse = 1'b0;
      upPulse  = 1'b0;
      upLevel  = 1'b0;
      modelReset();
      #21;
      checkResetValues("reset");
      #1 reset_n = 1'b1;
      idleCycles("idle", 3);

      // Full Set cycle, pulses ten cycles apart.
      base = obsClr;
      for (int k = 0; k < 4; k++) begin
         applyStimulus("setStep", 1, 0, 0);
         checkOutput("setStepMode", 32'(mode), setModes[k]);
         idleCycles("setGap", 9);
      end
      checkOutput("setCycleClr", obsClr - base, 1);

      // Up in NORMAL and ARMED is ignored.
      base = obsMin + obsHour;
      applyStimulus("upNormal", 0, 1, 0);
      idleCycles("gap", 2);
      applyStimulus("toArmed", 1, 0, 0);
      idleCycles("gap", 2);
      applyStimulus("upArmed", 0, 1, 0);
      idleCycles("gap", 2);
      checkOutput("upIgnored", (obsMin + obsHour) - base, 0);

      // Enter SET_MIN, watch one blink period, then edit in the OFF phase.
      base = obsMin;
      applyStimulus("toSetMin", 1, 0, 0);
      checkOutput("blinkOn", 32'(blank), 0);
      idleCycles("blink", 8);
      checkOutput("blinkOff", 32'(blank), 4'h3);
      idleCycles("blink", 2);
      applyStimulus("upOff", 0, 1, 0);
      checkOutput("upOffMask", 32'(blank), 0);
      checkOutput("upOffStrobe", 32'(incMin), 1);
      for (int k = 0; k < 2; k++) begin
         idleCycles("minGap", 4);
         applyStimulus("upMin", 0, 1, 0);
      end
      idleCycles("minGap", 3);
      checkOutput("minCount", obsMin - base, 3);

      // Set and Up together: Set wins.
      base = obsHour;
      applyStimulus("setUp", 1, 1, 0);
      checkOutput("setUpMode", 32'(mode), 3);
      checkOutput("setUpNoMin", 32'(incMin), 0);
      idleCycles("gap", 3);

      // Press and hold Up in SET_HOUR.
      holdSeen.delete();
      applyStimulus("hold", 0, 1, 1);
      if (incHour) holdSeen.push_back(1);
      for (int n = 1; n <= 40; n++) begin
         applyStimulus("hold", 0, 0, 1);
         if (incHour) holdSeen.push_back(n + 1);
      end
      for (int n = 41; n < 48; n++) begin
         applyStimulus("release", 0, 0, 0);
         if (incHour) holdSeen.push_back(n + 1);
      end
      checkOutput("holdCount", holdSeen.size(), 6);
      for (int i = 0; i < 6; i++)
         checkOutput("holdAt", (i < holdSeen.size()) ? holdSeen[i] : -1, holdExp[i]);

      // Set in the middle of a hold stops the repeat.
      applyStimulus("hold2", 0, 1, 1);
      for (int n = 0; n < 24; n++) applyStimulus("hold2", 0, 0, 1);
      base = obsHour;
      applyStimulus("setMidHold", 1, 0, 1);
      checkOutput("midHoldMode", 32'(mode), 0);
      checkOutput("midHoldClr", 32'(clearSec), 1);
      for (int n = 0; n < 20; n++) applyStimulus("afterSet", 0, 0, 1);
      checkOutput("afterSetStrobes", obsHour - base, 0);
      idleCycles("gap", 2);

      // Idle timeout from ARMED.
      base = obsClr;
      applyStimulus("toArmed", 1, 0, 0);
      idleCycles("armedIdle", 191);
      checkOutput("preTimeout", 32'(mode), 1);
      applyStimulus("armedIdle", 0, 0, 0);
      checkOutput("timeoutMode", 32'(mode), 0);
      checkOutput("timeoutNoClr", obsClr - base, 0);
      idleCycles("gap", 2);

      // Asynchronous reset in the middle of an auto-repeat.
      applyStimulus("toArmed", 1, 0, 0);
      applyStimulus("toSetMin", 1, 0, 0);
      applyStimulus("rptPress", 0, 1, 1);
      for (int n = 0; n < 22; n++) applyStimulus("rptHold", 0, 0, 1);
      #3 reset_n = 1'b0;
      #1;
      checkResetValues("midReset");
      modelReset();
      #2 reset_n = 1'b1;
      base = obsMin + obsHour;
      for (int n = 0; n < 30; n++) applyStimulus("postReset", 0, 0, 1);
      checkOutput("postResetStrobes", (obsMin + obsHour) - base, 0);
      checkOutput("postResetMode", 32'(mode), 0);
      idleCycles("gap", 2);

      // Randomised traffic with quiet stretches long enough to time out.
      holdLeft = 0;
      for (int i = 0; i < 3000; i++) begin
         if ((i % 1000) >= 750) begin
            s = 0;
            u = 0;
            holdLeft = 0;
         end else begin
            s = ($urandom_range(0, 99) < 3);
            u = ($urandom_range(0, 99) < 8);
            if (u) holdLeft = $urandom_range(0, 45);
            else if ($urandom_range(0, 199) == 0) holdLeft = 10;
         end
         l = (holdLeft > 0);
         if (holdLeft > 0) holdLeft--;
         applyStimulus("random", s, u, l);
      end

      setPulse = 1'b0;
      upPulse  = 1'b0;
      upLevel  = 1'b0;
      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
